// File: rtl/calc_op_scheduler.sv
// Calculator operation controller: button sync/debounce, fixed-priority arbitration, operand latch
// and a shared iterative add/sub/mul/div datapath. Optional macro: CALC_NEG_RESULT_EN (signed subtract).
module calc_op_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        add,
  input  logic        subtract,
  input  logic        multiply,
  input  logic        divide,
  input  logic [6:0]  opa,
  input  logic [6:0]  opb,
  output logic [13:0] result,
  output logic        neg,
  output logic        div_zero,
  output logic [1:0]  op_code,
  output logic        busy,
  output logic        result_valid,
  output logic        drop
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t r_state, w_next;
  op_t    r_op_code, w_pick;

  logic [3:0]    w_raw;
  logic [3:0]    r_sync1, r_sync2, r_lvl, r_lvl_d;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    w_req;
  logic          w_any, w_multi, w_accept, w_drop_nxt, w_last;

  logic [6:0]  r_a, r_b, r_wk, r_rem;
  logic [13:0] r_acc, r_mcand;
  logic [2:0]  r_iter;
  logic [13:0] r_result;
  logic        r_neg, r_dz, r_drop;

  logic [13:0] w_acc_nxt;
  logic [7:0]  w_rem_sh;
  logic [8:0]  w_trial;
  logic [6:0]  w_q_nxt, w_rem_nxt;
  logic [7:0]  w_sum;
  logic [13:0] w_res;
  logic        w_neg, w_dz;

  assign w_raw = {divide, multiply, subtract, add};

  // Level rises on the sample that brings the counter to CMAX, then holds while input stays high.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int unsigned i = 0; i < 4; i++) begin
        if (!r_sync2[i]) begin
          r_cnt[i] <= '0;
          r_lvl[i] <= 1'b0;
        end else if (r_cnt[i] != CMAX) begin
          r_cnt[i] <= r_cnt[i] + CONE;
          r_lvl[i] <= ((r_cnt[i] + CONE) == CMAX);
        end
      end
    end
  end

  assign w_req   = r_lvl & ~r_lvl_d;
  assign w_any   = |w_req;
  assign w_multi = |(w_req & (w_req - 4'd1));

  always_comb begin
    w_pick = OP_DIV;
    if (w_req[0])      w_pick = OP_ADD;
    else if (w_req[1]) w_pick = OP_SUB;
    else if (w_req[2]) w_pick = OP_MUL;
  end

  assign w_last = (r_op_code == OP_ADD) || (r_op_code == OP_SUB) ||
                  ((r_op_code == OP_DIV) && (r_b == 7'd0)) || (r_iter == 3'd6);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_drop_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_accept   = 1'b1;
          w_next     = S_LOAD;
          w_drop_nxt = w_multi;
        end
      end
      S_LOAD: begin
        w_next     = S_EXEC;
        w_drop_nxt = w_any;
      end
      S_EXEC: begin
        if (w_last) w_next = S_DONE;
        w_drop_nxt = w_any;
      end
      S_DONE: begin
        w_next     = S_IDLE;
        w_drop_nxt = w_any;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply (r_wk = multiplier) or restoring divide (r_wk = dividend/quotient).
  assign w_acc_nxt = r_wk[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh  = {r_rem, r_wk[6]};
  assign w_trial   = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_q_nxt   = {r_wk[5:0], ~w_trial[8]};
  assign w_rem_nxt = w_trial[8] ? w_rem_sh[6:0] : w_trial[6:0];
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_res = '0;
    w_neg = 1'b0;
    w_dz  = 1'b0;
    case (r_op_code)
      OP_ADD: w_res = {6'b0, w_sum};
      OP_SUB: begin
`ifdef CALC_NEG_RESULT_EN
        if (r_a < r_b) begin
          w_res = {7'b0, r_b - r_a};
          w_neg = 1'b1;
        end else begin
          w_res = {7'b0, r_a - r_b};
        end
`else
        if (r_a >= r_b) w_res = {7'b0, r_a - r_b};
`endif
      end
      OP_MUL: w_res = w_acc_nxt;
      OP_DIV: begin
        if (r_b == 7'd0) w_dz = 1'b1;
        else             w_res = {7'b0, w_q_nxt};
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_op_code <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_wk      <= '0;
      r_rem     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_iter    <= '0;
      r_result  <= '0;
      r_neg     <= 1'b0;
      r_dz      <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_drop <= w_drop_nxt;
      if (w_accept) r_op_code <= w_pick;
      case (r_state)
        S_LOAD: begin
          r_a     <= opa;
          r_b     <= opb;
          r_wk    <= (r_op_code == OP_MUL) ? opb : opa;
          r_rem   <= '0;
          r_acc   <= '0;
          r_mcand <= {7'b0, opa};
          r_iter  <= '0;
        end
        S_EXEC: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_wk    <= (r_op_code == OP_MUL) ? (r_wk >> 1) : w_q_nxt;
          r_rem   <= w_rem_nxt;
          r_iter  <= r_iter + 3'd1;
          if (w_last) begin
            r_result <= w_res;
            r_neg    <= w_neg;
            r_dz     <= w_dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign neg          = r_neg;
  assign div_zero     = r_dz;
  assign op_code      = r_op_code;
  assign busy         = (r_state == S_LOAD) || (r_state == S_EXEC);
  assign result_valid = (r_state == S_DONE);
  assign drop         = r_drop;

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Scoreboard bench for calc_op_scheduler: expected results queued at stimulus, checked by a monitor.
module tb_calc_op_scheduler;
  localparam int N = 4;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btn = '0;
  logic [6:0]  opa = '0, opb = '0;
  logic [13:0] result;
  logic        neg, div_zero, busy, result_valid, drop;
  logic [1:0]  op_code;

  calc_op_scheduler #(.DEBOUNCE_CYCLES(N)) dut (
    .clkin(clkin), .reset(reset),
    .add(btn[0]), .subtract(btn[1]), .multiply(btn[2]), .divide(btn[3]),
    .opa(opa), .opb(opb),
    .result(result), .neg(neg), .div_zero(div_zero), .op_code(op_code),
    .busy(busy), .result_valid(result_valid), .drop(drop)
  );

  always #5 clkin = ~clkin;

  typedef struct {int res; int ng; int dz; int opc; int lat;} exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int n_valid = 0, n_drop = 0, n_acc = 0;
  int t_press = 0, t_acc = 0, busy_cnt = 0;
  bit prev_busy = 1'b0, lat_chk = 1'b1;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Reference model from the arithmetic rules, not the iteration scheme.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    e.res = 0; e.ng = 0; e.dz = 0; e.opc = op; e.lat = 2;
    case (op)
      0: e.res = a + b;
      1: begin
`ifdef CALC_NEG_RESULT_EN
        e.res = (a < b) ? b - a : a - b;
        e.ng  = (a < b) ? 1 : 0;
`else
        e.res = (a < b) ? 0 : a - b;
`endif
      end
      2: begin e.res = a * b; e.lat = 8; end
      default: begin
        if (b == 0) e.dz = 1;
        else begin e.res = a / b; e.lat = 8; end
      end
    endcase
    return e;
  endfunction

  always @(negedge clkin) begin
    if (reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy && !prev_busy) begin
        n_acc++;
        t_acc    = cyc;
        busy_cnt = 0;
        if (lat_chk) chk_rng("accept_latency", cyc - t_press, N + 1, N + 5);
      end
      if (busy) busy_cnt++;
      if (drop) n_drop++;
      if (result_valid) begin
        n_valid++;
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result",   int'(result),   e.res);
          chk("neg",      int'(neg),      e.ng);
          chk("div_zero", int'(div_zero), e.dz);
          chk("op_code",  int'(op_code),  e.opc);
          chk("valid_latency", cyc - t_acc, e.lat);
          chk("busy_cycles",   busy_cnt,    e.lat);
        end
      end
      prev_busy = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic btn_set(input logic [3:0] m);
    btn = btn | m;
    t_press = cyc;
  endtask

  task automatic wait_valid(input int prev, input int budget, input string nm);
    int k;
    k = 0;
    while (n_valid == prev && k < budget) begin step(1); k++; end
    if (n_valid == prev) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_busy(input int budget, input string nm);
    int k;
    k = 0;
    while (!busy && k < budget) begin step(1); k++; end
    if (!busy) chk({nm, "_busy_timeout"}, 0, 1);
  endtask

  // Press one or more buttons with an expectation already queued, then wait for completion.
  task automatic run_op(input int op, input int a, input int b, input int hold, input string nm);
    int v0;
    v0 = n_valid;
    opa = 7'(a); opb = 7'(b);
    q.push_back(model(op, a, b));
    btn_set(4'(1 << op));
    step(hold);
    btn = '0;
    wait_valid(v0, 60, nm);
    step(4);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_result"},   int'(result), 0);
    chk({nm, "_neg"},      int'(neg), 0);
    chk({nm, "_div_zero"}, int'(div_zero), 0);
    chk({nm, "_op_code"},  int'(op_code), 0);
    chk({nm, "_busy"},     int'(busy), 0);
    chk({nm, "_valid"},    int'(result_valid), 0);
    chk({nm, "_drop"},     int'(drop), 0);
  endtask

  initial begin
    int v0, d0, a0;
    step(3);
    chk_zero_outputs("reset");
    reset = 1'b0;
    step(3);

    d0 = n_drop;
    run_op(0, 42, 57, 10, "add");
    run_op(1, 12, 30, 10, "sub");

    // Operand change after LOAD must not disturb the multiply in flight.
    v0 = n_valid;
    opa = 7'd99; opb = 7'd99;
    q.push_back(model(2, 99, 99));
    btn_set(4'b0100);
    wait_busy(40, "mul");
    step(2);
    opb = 7'd5;
    btn = '0;
    wait_valid(v0, 40, "mul");
    step(4);

    run_op(3, 99, 7, 10, "div");
    run_op(3, 55, 0, 10, "div0");
    chk("no_drop_directed", n_drop - d0, 0);

    // Short glitch must never be accepted.
    a0 = n_acc; v0 = n_valid;
    btn_set(4'b1000);
    step(3);
    btn = '0;
    step(20);
    chk("glitch_accepts", n_acc - a0, 0);
    chk("glitch_valids",  n_valid - v0, 0);

    // Simultaneous add and divide: add wins, divide dropped once.
    d0 = n_drop; v0 = n_valid;
    opa = 7'd20; opb = 7'd3;
    q.push_back(model(0, 20, 3));
    btn_set(4'b1001);
    step(10);
    btn = '0;
    wait_valid(v0, 40, "arb");
    step(4);
    chk("arb_drops", n_drop - d0, 1);

    // Multiply arriving while a divide is busy is discarded.
    lat_chk = 1'b0;
    d0 = n_drop; v0 = n_valid;
    opa = 7'd100; opb = 7'd9;
    q.push_back(model(3, 100, 9));
    btn_set(4'b1000);
    wait_busy(40, "busy_drop");
    btn_set(4'b0100);
    step(30);
    btn = '0;
    step(4);
    chk("busy_drop_drops",  n_drop - d0, 1);
    chk("busy_drop_valids", n_valid - v0, 1);

    // Reset during multiply EXEC, with multiply held through release.
    d0 = n_drop;
    opa = 7'd77; opb = 7'd88;
    q.push_back(model(2, 77, 88));
    btn_set(4'b0100);
    wait_busy(40, "rst");
    step(3);
    #2 reset = 1'b1;
    #1;
    chk_zero_outputs("abort");
    q.delete();
    q.push_back(model(2, 77, 88));
    v0 = n_valid;
    step(3);
    reset = 1'b0;
    wait_valid(v0, 60, "rst_rel");
    step(30);
    chk("rst_rel_valids", n_valid - v0, 1);
    chk("rst_rel_drops",  n_drop - d0, 0);
    btn = '0;
    step(6);
    lat_chk = 1'b1;

    for (int i = 0; i < 24; i++) begin
      int op, a, b;
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 127));
      b  = int'($urandom_range(0, 127));
      if (op == 3 && $urandom_range(0, 3) == 0) b = 0;
      run_op(op, a, b, int'($urandom_range(6, 12)), "rand");
    end

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d expected=0", cyc);
    $fatal(1);
  end
endmodule

// File: doc/calc_op_scheduler.md
# calc_op_scheduler

Operation controller for the four-digit calculator. It synchronizes and debounces the four raw operator buttons, arbitrates simultaneous presses, and latches the two operands. It then sequences a shared iterative datapath: single-cycle add/subtract, shift-add multiply, restoring divide. The registered result, flags and handshake go to the BCD conversion and display stage.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable-high synchronized samples required before a press is accepted (5 ms at 100 MHz).
- `clkin`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high.
- `add`, `subtract`, `multiply`, `divide`  in  1 each  raw, asynchronous operator buttons.
- `opa`  in  7  left operand, binary 0..127; the display path supplies 0..99.
- `opb`  in  7  right operand, binary 0..127.
- `result`  out  14  magnitude of the last completed operation.
- `neg`  out  1  last subtract result was negative.
- `div_zero`  out  1  last divide had `opb == 0`.
- `op_code`  out  2  last accepted operation: 0 add, 1 sub, 2 mul, 3 div.
- `busy`  out  1  datapath sequencing in progress.
- `result_valid`  out  1  one-cycle pulse when `result`, `neg` and `div_zero` update.
- `drop`  out  1  one-cycle pulse when a request is discarded.

## Operation
- Reset values: `result` = 0, `neg` = 0, `div_zero` = 0, `op_code` = 0, `busy` = 0, `result_valid` = 0, `drop` = 0. Synchronizers, debounce counters, debounced levels and FSM also clear; FSM returns to IDLE.
- Per button, in this order:
  - 2-flop synchronizer.
  - Saturating debounce counter; any low sample clears the counter and the debounced level.
  - Debounced level rises when the counter reaches `DEBOUNCE_CYCLES`.
  - Rising edge of the debounced level produces a one-cycle request.
- Arbitration: fixed priority add > subtract > multiply > divide.
  - Only in IDLE: the highest-priority request is accepted.
  - Every other request in the same cycle pulses `drop` once.
  - Any request outside IDLE pulses `drop` once and is discarded; nothing is queued.
- FSM states: IDLE → LOAD → EXEC → DONE → IDLE.
  - LOAD: samples `opa` and `opb` into internal registers. Later changes to `opa`/`opb` do not affect the operation in flight.
  - EXEC: 1 cycle for add, subtract and divide-by-zero; 7 cycles for multiply and divide.
  - DONE: registers the outputs, pulses `result_valid`, returns to IDLE on the next edge.
- Arithmetic:
  - add: `opa + opb` (max 254).
  - sub: `|opa − opb|`, with `neg` = (`opa < opb`).
  - mul: 7-iteration shift-add over `opb` bits, LSB first (max 16129, fits 14 bits, no overflow).
  - div: 7-iteration restoring divide, MSB first; `result` = quotient and the remainder is discarded.
  - div with `opb == 0`: `result` = 0, `div_zero` = 1.
  - `neg` and `div_zero` are cleared on every completion that does not set them.
- `result`, `neg`, `div_zero` and `op_code` hold until the next DONE. `op_code` updates in LOAD.
- Reset mid-operation aborts immediately. No `result_valid` is produced and all outputs return to reset values.
- A button held through reset release produces exactly one request, `DEBOUNCE_CYCLES` after release.

## Timing
- Acceptance latency: between `DEBOUNCE_CYCLES`+2 and `DEBOUNCE_CYCLES`+4 `clkin` edges after the raw input rises. Benches use a ±2-cycle window.
- Let edge A be the IDLE→LOAD edge.
- `busy` is high from after edge A until DONE is entered.
- `busy` is low in DONE and in IDLE.
- `result_valid` is high for exactly one cycle:
  - add, sub, div-by-zero: after edge A+2.
  - mul, div: after edge A+8.
- A request arriving in the DONE cycle is dropped.
- The earliest next acceptance is the cycle after DONE.
- `drop` is registered: it is high the cycle after the offending request.

## Configuration
- `CALC_NEG_RESULT_EN` defined: subtract behaves as above, giving magnitude plus `neg`.
- `CALC_NEG_RESULT_EN` undefined:
  - Subtract saturates: `result` = 0 when `opa < opb`.
  - `neg` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Add: `opa` = 42, `opb` = 57, press add for 10 cycles → one `result_valid` pulse 2 edges after acceptance; `result` = 99, `neg` = 0, `op_code` = 0, no `drop`.
- Subtract: `opa` = 12, `opb` = 30 → `result` = 18, `neg` = 1 with the macro; `result` = 0, `neg` = 0 without it.
- Multiply: `opa` = 99, `opb` = 99, press multiply and change `opb` to 5 after LOAD → `busy` high for 8 cycles, `result` = 9801, valid at A+8.
- Divide and bounce:
  - `opa` = 99, `opb` = 7 → `result` = 14.
  - `opb` = 0 → `result` = 0, `div_zero` = 1, valid at A+2.
  - A 3-cycle glitch on `divide` → no acceptance.
- Arbitration and drop:
  - add and divide rising in the same cycle → add executes, one `drop`.
  - multiply pressed while `busy` → `drop`, no second `result_valid`.
- Reset during multiply EXEC → all outputs 0 at once, no `result_valid`; a held multiply yields exactly one new operation after release.
